multicycle_chunk_adder: RTL and testbench

MULTICYCLE_CHUNK_ADDER -- requirements
Module: multicycle_chunk_adder

---
 rtl/adder_pkg.sv | 19 +
 rtl/ripple_chunk_adder.sv | 26 ++
 rtl/multicycle_chunk_adder.sv | 118 +++++++++++
 tb/tb_multicycle_chunk_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder: FSM encodings,
// default geometry and a helper for sizing the slice counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Slice counter width: ceil(log2(slices)), never less than one bit.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// One CHUNK-bit slice built as a ripple chain of full adders. The carry
// into the slice MSB is exposed so the top can derive signed overflow.
module ripple_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout  = w_c[CHUNK];
  assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder/subtractor: operands are captured once, then summed one
// CHUNK-bit slice per cycle (LSB first) through a registered carry. The
// result is held in DONE until the consumer takes it.
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int SLICES = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
    $error("multicycle_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_c_msb;
  logic             w_accept;

  assign w_accept  = (r_state == IDLE) && In_valid;
  assign w_a_slice = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_b_slice = r_b[int'(r_idx) * CHUNK +: CHUNK];

  ripple_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .i_a     (w_a_slice),
    .i_b     (w_b_slice),
    .i_cin   (r_carry),
    .o_sum   (w_slice_sum),
    .o_cout  (w_slice_cout),
    .o_c_msb (w_slice_c_msb)
  );

  // Operand capture: B is pre-inverted for subtraction so RUN only ever adds.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_a <= A;
      r_b <= B ^ {WIDTH{Sub}};
    end
  end

  // Control FSM with slice counter, carry chain and result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_valid) begin
            r_carry <= Sub ? 1'b1 : Cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= w_slice_c_msb ^ w_slice_cout;
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (Out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign In_ready  = (r_state == IDLE);
  assign Out_valid = (r_state == DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Bench for multicycle_chunk_adder: a 16/4 instance driven with directed and
// random operations against a behavioural model, plus an 8/8 instance.
module tb_multicycle_chunk_adder;

  localparam int W      = 16;
  localparam int C      = 4;
  localparam int SLICES = W / C;

  logic          Clk;
  logic          Rst_n;
  logic          In_valid, In_ready, Out_valid, Out_ready;
  logic [W-1:0]  A, B, Sum;
  logic          Cin, Sub, Cout, Overflow;

  logic          In_valid8, In_ready8, Out_valid8, Out_ready8;
  logic [7:0]    A8, B8, Sum8;
  logic          Cin8, Sub8, Cout8, Overflow8;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 0;

  multicycle_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
  );

  multicycle_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid8), .In_ready(In_ready8),
    .A(A8), .B(B8), .Cin(Cin8), .Sub(Sub8), .Out_valid(Out_valid8),
    .Out_ready(Out_ready8), .Sum(Sum8), .Cout(Cout8), .Overflow(Overflow8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {overflow, carry_out, sum}.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    return {ovf, full[16], full[15:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return {ovf, full[8], full[7:0]};
  endfunction

  // Behavioural model of the handshake timeline and the held result.
  int          m_state;  // 0 waiting, 1 busy, 2 holding result
  int          m_left;
  logic [17:0] m_pend;
  logic [15:0] m_sum;
  logic        m_cout, m_ovf;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_state = 0; m_left = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      case (m_state)
        0: if (In_valid) begin
             m_pend  = ref16(A, B, Cin, Sub);
             m_left  = SLICES;
             m_state = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_state = 2;
               m_sum   = m_pend[15:0];
               m_cout  = m_pend[16];
               m_ovf   = m_pend[17];
             end
           end
        default: if (Out_ready) m_state = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_on && Rst_n) begin
      chk("in_ready", {31'd0, In_ready}, {31'd0, (m_state == 0)});
      chk("out_valid", {31'd0, Out_valid}, {31'd0, (m_state == 2)});
      if (m_state == 2) begin
        chk("model_sum", {16'd0, Sum}, {16'd0, m_sum});
        chk("model_cout", {31'd0, Cout}, {31'd0, m_cout});
        chk("model_ovf", {31'd0, Overflow}, {31'd0, m_ovf});
      end
    end
  end

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; In_valid = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Scramble inputs while busy, then check latency, result, hold and release.
  task automatic wait_result(input logic [15:0] es, input logic ec, input logic eo,
                             input int hold, input bit keep_valid);
    int  cnt;
    bit  seen;
    cnt = 0; seen = 0;
    In_valid = keep_valid;
    while (!seen && cnt < 40) begin
      A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom); Sub = 1'($urandom); Out_ready = 1'($urandom);
      @(posedge Clk);
      cnt++;
      #1;
      seen = Out_valid;
    end
    Out_ready = 1'b0;
    chk("latency", cnt, SLICES);
    chk("sum", {16'd0, Sum}, {16'd0, es});
    chk("cout", {31'd0, Cout}, {31'd0, ec});
    chk("ovf", {31'd0, Overflow}, {31'd0, eo});
    repeat (hold) begin
      @(posedge Clk);
      #1;
      chk("hold_valid", {31'd0, Out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, In_ready}, 32'd0);
      chk("hold_sum", {16'd0, Sum}, {16'd0, es});
      chk("hold_cout", {31'd0, Cout}, {31'd0, ec});
      chk("hold_ovf", {31'd0, Overflow}, {31'd0, eo});
    end
    Out_ready = 1'b1;
    @(posedge Clk);
    #1;
    Out_ready = 1'b0;
    chk("release_in_ready", {31'd0, In_ready}, 32'd1);
    chk("release_valid", {31'd0, Out_valid}, 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    logic [9:0] e;
    e = ref8(a, b, cin, sub);
    A8 = a; B8 = b; Cin8 = cin; Sub8 = sub; In_valid8 = 1'b1;
    @(posedge Clk);
    #1;
    In_valid8 = 1'b0;
    @(posedge Clk);
    #1;
    chk("w8_valid", {31'd0, Out_valid8}, 32'd1);
    chk("w8_in_ready", {31'd0, In_ready8}, 32'd0);
    chk("w8_sum", {24'd0, Sum8}, {24'd0, e[7:0]});
    chk("w8_cout", {31'd0, Cout8}, {31'd0, e[8]});
    chk("w8_ovf", {31'd0, Overflow8}, {31'd0, e[9]});
    Out_ready8 = 1'b1;
    @(posedge Clk);
    #1;
    Out_ready8 = 1'b0;
    chk("w8_release", {31'd0, In_ready8}, 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, In_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, Out_valid}, 32'd0);
    chk({tag, "_sum"}, {16'd0, Sum}, 32'd0);
    chk({tag, "_cout"}, {31'd0, Cout}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, Overflow}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] e;

    Rst_n = 1'b1; In_valid = 0; Out_ready = 0; A = 0; B = 0; Cin = 0; Sub = 0;
    In_valid8 = 0; Out_ready8 = 0; A8 = 0; B8 = 0; Cin8 = 0; Sub8 = 0;
    #2 Rst_n = 1'b0;
    #1 chk_reset_values("por");
    #19 Rst_n = 1'b1;
    chk_on = 1;
    @(posedge Clk);
    #1;

    // Directed boundary cases with hand-computed results.
    start(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_result(16'h0000, 1'b1, 1'b0, 0, 0);
    start(16'h7FFF, 16'h0000, 1'b1, 1'b0); wait_result(16'h8000, 1'b0, 1'b1, 0, 0);
    start(16'h8000, 16'h0001, 1'b0, 1'b1); wait_result(16'h7FFF, 1'b1, 1'b1, 0, 0);
    start(16'h0005, 16'h0007, 1'b0, 1'b1); wait_result(16'hFFFE, 1'b0, 1'b0, 0, 0);

    // Back-pressure with In_valid held high; second op waits for IDLE.
    start(16'h1111, 16'h2222, 1'b0, 1'b0); wait_result(16'h3333, 1'b0, 1'b0, 3, 1);
    start(16'h0F0F, 16'h1010, 1'b0, 1'b0); wait_result(16'h1F1F, 1'b0, 1'b0, 0, 0);

    // Reset during the second RUN cycle abandons the operation.
    start(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    In_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk_on = 0;
    Rst_n = 1'b0;
    #1 chk_reset_values("midrun");
    @(posedge Clk);
    #1;
    chk("rst_no_valid", {31'd0, Out_valid}, 32'd0);
    Rst_n = 1'b1;
    chk_on = 1;
    start(16'h1234, 16'h1111, 1'b0, 1'b0); wait_result(16'h2345, 1'b0, 1'b0, 0, 0);

    // Randomized operations against the reference arithmetic.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 10 == 0) ra = 16'h8000;
      if (i % 10 == 1) rb = 16'hFFFF;
      rc = 1'($urandom); rs = 1'($urandom);
      e = ref16(ra, rb, rc, rs);
      start(ra, rb, rc, rs);
      wait_result(e[15:0], e[16], e[17], $urandom_range(0, 2), 0);
    end

    // Single-slice instance: latency 1.
    run8(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
